// File: rtl/mem_if_ctrl_pkg.sv
// Shared constants for the memory interface controller: FSM encodings,
// port ids and default bus widths.
package mem_if_ctrl_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned CNT_W  = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_if_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; bit 1 is the data port, bit 0 the fetch
// port. The grant is combinational and only issued while enabled.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_last_d;

  // Data wins a tie unless it won the previous grant
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[1] && (!req[0] || !r_last_d)) begin
        gnt[1] = 1'b1;
      end else if (req[0]) begin
        gnt[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (|gnt) begin
      r_last_d <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_if_ctrl.sv
// Single-outstanding memory controller arbitrating fetch and load/store ports
// onto a synchronous-read block RAM, absorbing its read latency.
module mem_if_ctrl
  import mem_if_ctrl_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_port;
  logic             r_op_we;
  logic             r_ram_we;
  logic [AW-1:0]    r_ram_addr;
  logic [DW-1:0]    r_ram_din;
  logic [DW-1:0]    r_if_rdata;
  logic [DW-1:0]    r_d_rdata;
  logic             r_if_rvalid;
  logic             r_d_done;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_port_nxt;
  logic             w_op_we_nxt;
  logic             w_ram_we_nxt;
  logic [AW-1:0]    w_ram_addr_nxt;
  logic [DW-1:0]    w_ram_din_nxt;
  logic [DW-1:0]    w_if_rdata_nxt;
  logic [DW-1:0]    w_d_rdata_nxt;
  logic             w_if_rvalid_nxt;
  logic             w_d_done_nxt;
  logic [1:0]       w_gnt;
  logic             w_arb_en;

  assign w_arb_en = (r_state == ST_IDLE) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (w_arb_en),
    .req   ({d_req, if_req}),
    .gnt   (w_gnt)
  );

  assign if_gnt    = w_gnt[0];
  assign d_gnt     = w_gnt[1];
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign busy      = r_busy;

  // Next-state and registered-output logic; ram_we defaults low so it only
  // survives the single ACCESS cycle following a store grant.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_port_nxt      = r_port;
    w_op_we_nxt     = r_op_we;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_din_nxt   = r_ram_din;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_if_rvalid_nxt = 1'b0;
    w_d_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt[1]) begin
          w_ram_addr_nxt = d_addr;
          w_ram_din_nxt  = d_wdata;
          w_ram_we_nxt   = d_we;
          w_port_nxt     = PORT_D;
          w_op_we_nxt    = d_we;
          w_state_nxt    = ST_ACCESS;
        end else if (w_gnt[0]) begin
          w_ram_addr_nxt = if_addr;
          w_port_nxt     = PORT_IF;
          w_op_we_nxt    = 1'b0;
          w_state_nxt    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_op_we) begin
          w_d_done_nxt = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_cnt_nxt   = CNT_W'(RD_LAT - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          if (r_port == PORT_D) begin
            w_d_rdata_nxt = ram_dout;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt  = ram_dout;
            w_if_rvalid_nxt = 1'b1;
          end
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_port      <= PORT_IF;
      r_op_we     <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_done    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_port      <= w_port_nxt;
      r_op_we     <= w_op_we_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_din   <= w_ram_din_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_rvalid <= w_if_rvalid_nxt;
      r_d_done    <= w_d_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mem_if_ctrl.sv
// Bench for mem_if_ctrl: instance A (RD_LAT=1) checked every cycle against a
// transaction-timing model; instance B (RD_LAT=2) checked with directed values.
module tb_mem_if_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  // Instance A signals
  logic        if_req_a, d_req_a, d_we_a;
  logic [7:0]  if_addr_a, d_addr_a;
  logic [15:0] d_wdata_a;
  logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_done_a, ram_we_a, busy_a;
  logic [15:0] if_rdata_a, d_rdata_a, ram_din_a, ram_dout_a;
  logic [7:0]  ram_addr_a;
  logic [15:0] mem_a [256];

  // Instance B signals
  logic        if_req_b, d_req_b, d_we_b;
  logic [7:0]  if_addr_b, d_addr_b;
  logic [15:0] d_wdata_b;
  logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_done_b, ram_we_b, busy_b;
  logic [15:0] if_rdata_b, d_rdata_b, ram_din_b, ram_dout_b, dout_b1;
  logic [7:0]  ram_addr_b;
  logic [15:0] mem_b [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_if_ctrl #(.AW(8), .DW(16), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
    .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_gnt(d_gnt_a), .d_done(d_done_a), .d_rdata(d_rdata_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_din(ram_din_a),
    .ram_dout(ram_dout_a), .busy(busy_a)
  );

  mem_if_ctrl #(.AW(8), .DW(16), .RD_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
    .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_gnt(d_gnt_b), .d_done(d_done_b), .d_rdata(d_rdata_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
    .ram_dout(ram_dout_b), .busy(busy_b)
  );

  // Block RAMs: latency 1 for A, 2 for B, preloaded with A000+i
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 16'hA000 + 16'(i);
        mem_b[i] <= 16'hA000 + 16'(i);
      end
    end else begin
      if (ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem_b[ram_addr_b] <= ram_din_b;
    end
    ram_dout_a <= mem_a[ram_addr_a];
    dout_b1    <= mem_b[ram_addr_b];
    ram_dout_b <= dout_b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model of instance A
  localparam int LAT_A = 1;
  logic [15:0] m_mem [256];
  bit          m_valid = 1'b0;
  bit          m_last_d;
  int          m_idle_from, m_done_cyc, m_we_cyc;
  bit          m_done_d, m_done_load;
  logic [15:0] m_pend, m_if_rdata, m_d_rdata, m_ram_din;
  logic [7:0]  m_ram_addr;
  bit          gnt_log [$];
  int          rv_cnt = 0, we_cnt = 0, last_rv_cyc = -1, last_dd_cyc = -1;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 16'hA000 + 16'(i);
  end

  always @(negedge clk) begin : mon_a
    bit idle, e_dg, e_ig;
    if (if_rvalid_a) begin rv_cnt++; last_rv_cyc = cyc; end
    if (d_done_a) last_dd_cyc = cyc;
    if (ram_we_a) we_cnt++;
    if (reset) begin
      chk("gnt_in_reset_a", 32'({if_gnt_a, d_gnt_a}), 32'd0);
      chk("gnt_in_reset_b", 32'({if_gnt_b, d_gnt_b}), 32'd0);
      m_valid = 1'b1;  m_last_d = 1'b0;
      m_idle_from = cyc + 1;  m_done_cyc = -1;  m_we_cyc = -1;
      m_if_rdata = '0;  m_d_rdata = '0;  m_ram_addr = '0;  m_ram_din = '0;
    end else if (m_valid) begin
      idle = (cyc >= m_idle_from);
      e_dg = idle && d_req_a && (!if_req_a || !m_last_d);
      e_ig = idle && if_req_a && !e_dg;
      if (cyc == m_done_cyc && m_done_load) begin
        if (m_done_d) m_d_rdata = m_pend; else m_if_rdata = m_pend;
      end
      chk("if_gnt",    32'(if_gnt_a),    32'(e_ig));
      chk("d_gnt",     32'(d_gnt_a),     32'(e_dg));
      chk("busy",      32'(busy_a),      32'(!idle));
      chk("ram_we",    32'(ram_we_a),    32'(cyc == m_we_cyc));
      chk("if_rvalid", 32'(if_rvalid_a), 32'(cyc == m_done_cyc && !m_done_d));
      chk("d_done",    32'(d_done_a),    32'(cyc == m_done_cyc && m_done_d));
      chk("if_rdata",  32'(if_rdata_a),  32'(m_if_rdata));
      chk("d_rdata",   32'(d_rdata_a),   32'(m_d_rdata));
      chk("ram_addr",  32'(ram_addr_a),  32'(m_ram_addr));
      chk("ram_din",   32'(ram_din_a),   32'(m_ram_din));
      if (e_dg) begin
        gnt_log.push_back(1'b1);
        m_last_d = 1'b1;  m_done_d = 1'b1;
        m_ram_addr = d_addr_a;  m_ram_din = d_wdata_a;
        if (d_we_a) begin
          m_mem[d_addr_a] = d_wdata_a;
          m_we_cyc = cyc + 1;  m_done_cyc = cyc + 2;  m_idle_from = cyc + 3;
          m_done_load = 1'b0;
        end else begin
          m_pend = m_mem[d_addr_a];
          m_done_cyc = cyc + 2 + LAT_A;  m_idle_from = cyc + 3 + LAT_A;
          m_done_load = 1'b1;
        end
      end else if (e_ig) begin
        gnt_log.push_back(1'b0);
        m_last_d = 1'b0;  m_done_d = 1'b0;  m_done_load = 1'b1;
        m_ram_addr = if_addr_a;  m_pend = m_mem[if_addr_a];
        m_done_cyc = cyc + 2 + LAT_A;  m_idle_from = cyc + 3 + LAT_A;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request on A, wait for grant, then drop and scramble the request inputs
  task automatic req_a(input bit is_d, input bit we, input logic [7:0] addr,
                       input logic [15:0] wd, output int gcyc);
    if (is_d) begin
      d_req_a = 1'b1; d_we_a = we; d_addr_a = addr; d_wdata_a = wd;
    end else begin
      if_req_a = 1'b1; if_addr_a = addr;
    end
    gcyc = -1;
    for (int k = 0; k < 20 && gcyc < 0; k++) begin
      @(negedge clk);
      if (is_d ? d_gnt_a : if_gnt_a) gcyc = cyc;
    end
    if (gcyc < 0) chk("grant_timeout", 32'd0, 32'd1);
    tick();
    if (is_d) begin
      d_req_a = 1'b0; d_addr_a = 8'h00; d_wdata_a = 16'h0000; d_we_a = 1'b0;
    end else begin
      if_req_a = 1'b0; if_addr_a = 8'h00;
    end
  endtask

  task automatic wait_idle_a(output int icyc);
    icyc = -1;
    for (int k = 0; k < 20 && icyc < 0; k++) begin
      @(negedge clk);
      if (!busy_a) icyc = cyc;
    end
    if (icyc < 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stim
    int  g, ic, base, rv0, we0, dc;
    bit  exp_ord [4];
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b1; ram_init = 1'b1;
    if_req_a = 0; d_req_a = 0; d_we_a = 0; if_addr_a = 0; d_addr_a = 0; d_wdata_a = 0;
    if_req_b = 0; d_req_b = 0; d_we_b = 0; if_addr_b = 0; d_addr_b = 0; d_wdata_b = 0;
    tick(); tick();
    ram_init = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ram_we", 32'(ram_we_a), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr_a), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata_a), 32'd0);
    tick();

    // Fetch 0x10
    req_a(1'b0, 1'b0, 8'h10, 16'h0, g);
    wait_idle_a(ic);
    chk("fetch_rvalid_lat", 32'(last_rv_cyc - g), 32'd3);
    chk("fetch_idle_at", 32'(ic - g), 32'd4);
    chk("fetch_rdata", 32'(if_rdata_a), 32'hA010);
    tick();

    // Contention: both held for four grants
    base = gnt_log.size();
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 8'h30;
    if_req_a = 1'b1; if_addr_a = 8'h40;
    for (int k = 0; k < 60 && gnt_log.size() < base + 4; k++) @(negedge clk);
    tick();
    d_req_a = 1'b0; if_req_a = 1'b0;
    chk("rr_count", 32'(gnt_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (gnt_log.size() > base + i) chk("rr_order", 32'(gnt_log[base + i]), 32'(exp_ord[i]));
    end
    wait_idle_a(ic);
    chk("rr_last_if_rdata", 32'(if_rdata_a), 32'hA040);
    tick();

    // Store 0x20 <= 1234, then load it back
    we0 = we_cnt;
    req_a(1'b1, 1'b1, 8'h20, 16'h1234, g);
    wait_idle_a(ic);
    chk("store_done_lat", 32'(last_dd_cyc - g), 32'd2);
    chk("store_idle_at", 32'(ic - g), 32'd3);
    chk("store_we_cycles", 32'(we_cnt - we0), 32'd1);
    tick();
    req_a(1'b1, 1'b0, 8'h20, 16'h0, g);
    wait_idle_a(ic);
    chk("load_done_lat", 32'(last_dd_cyc - g), 32'd3);
    chk("load_rdata", 32'(d_rdata_a), 32'h1234);
    tick();

    // Store BEEF; d_rdata untouched, RAM bus holds in IDLE
    req_a(1'b1, 1'b1, 8'h20, 16'hBEEF, g);
    wait_idle_a(ic);
    repeat (3) @(negedge clk);
    chk("beef_d_rdata", 32'(d_rdata_a), 32'h1234);
    chk("beef_ram_addr", 32'(ram_addr_a), 32'h20);
    chk("beef_ram_din", 32'(ram_din_a), 32'hBEEF);
    tick();

    // Reset during WAIT of a fetch
    rv0 = rv_cnt;
    req_a(1'b0, 1'b0, 8'h55, 16'h0, g);
    tick();
    reset = 1'b1;
    if_req_a = 1'b1; if_addr_a = 8'h56;
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 8'h57;
    tick();
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_d_gnt", 32'(d_gnt_a), 32'd1);
    chk("post_rst_if_gnt", 32'(if_gnt_a), 32'd0);
    tick();
    d_req_a = 1'b0; if_req_a = 1'b0;
    wait_idle_a(ic);
    chk("rst_no_rvalid", 32'(rv_cnt - rv0), 32'd0);
    chk("post_rst_d_rdata", 32'(d_rdata_a), 32'hA057);
    tick();

    // Instance B, RD_LAT=2: load 0xFF
    d_req_b = 1'b1; d_we_b = 1'b0; d_addr_b = 8'hFF;
    g = -1;
    for (int k = 0; k < 20 && g < 0; k++) begin
      @(negedge clk);
      if (d_gnt_b) g = cyc;
    end
    if (g < 0) chk("b_grant_timeout", 32'd0, 32'd1);
    tick();
    d_req_b = 1'b0; d_addr_b = 8'h00;
    dc = -1;
    for (int k = 0; k < 20 && dc < 0; k++) begin
      @(negedge clk);
      if (d_done_b) dc = cyc;
    end
    if (dc < 0) chk("b_done_timeout", 32'd0, 32'd1);
    chk("b_done_lat", 32'(dc - g), 32'd4);
    chk("b_d_rdata", 32'(d_rdata_b), 32'hA0FF);
    chk("b_if_rdata", 32'(if_rdata_b), 32'd0);
    @(negedge clk);
    chk("b_done_pulse", 32'(d_done_b), 32'd0);
    chk("b_idle", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_if_ctrl.md
Name: mem_if_ctrl

Overview:
- Memory interface controller that sits directly upstream of the 256x16 block-RAM wrapper and drives its clk/we/addr/din, consuming its dout.
- Arbitrates between an instruction-fetch port and a data (load/store) port from the CPU execution unit, and allows one outstanding access at a time.
- Absorbs the synchronous-read latency of the RAM and returns registered read data with a valid pulse.

Parameters:
- AW, 8, address width; 256 words.
- DW, 16, data word width.
- RD_LAT, 1, RAM read latency in cycles from address sampling to valid dout; legal values are 1 and 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held until granted.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DW  fetched word (registered).
- d_req  in  1  data request; level, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_done  out  1  one-cycle pulse; store written or load data valid.
- d_rdata  out  DW  load data (registered).
- ram_we  out  1  to RAM we.
- ram_addr  out  AW  to RAM addr.
- ram_din  out  DW  to RAM din.
- ram_dout  in  DW  from RAM dout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_din=0, if_rdata=0, d_rdata=0, if_rvalid=0, d_done=0, busy=0, state=IDLE, last_d=0.
- No grant is issued while reset is high.
- States are IDLE, ACCESS, WAIT, DONE.
- IDLE, grant rules:
  - gnt is asserted only in IDLE.
  - Single requester: that requester is granted.
  - Both requesting, round-robin: if last_d=1, fetch wins; otherwise data wins. last_d updates on every grant (1 = data won).
- IDLE, on grant (cycle 0):
  - Register ram_addr, ram_din and ram_we (we = d_we for a data store, 0 for a fetch).
  - Latch the winning port id and op.
  - Go to ACCESS.
  - Requesters may change their inputs after the gnt cycle.
- ACCESS (cycle 1):
  - RAM samples addr/we/din at the end of this cycle.
  - ram_we is forced to 0 at the end of ACCESS, so it is high for exactly one cycle.
  - Store: go to DONE.
  - Load/fetch: go to WAIT with the latency counter loaded to RD_LAT-1.
- WAIT:
  - Decrement the counter; when it reaches 0, capture ram_dout into d_rdata or if_rdata (per latched port) and go to DONE.
  - For RD_LAT=1, WAIT lasts one cycle.
- DONE:
  - Pulse d_done or if_rvalid for exactly one cycle.
  - Return to IDLE at the end of the cycle.
  - A new request is granted in the following cycle.
- Timing from grant cycle 0:
  - Store: d_done in cycle 2.
  - Load/fetch: done/rvalid in cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
  - Back-to-back throughput: one access per 3 cycles (store) or 3+RD_LAT cycles (read).
- ram_addr and ram_din hold their last values in IDLE (no glitching to 0).
- d_rdata and if_rdata hold until overwritten by the next read on the same port; a store never modifies d_rdata.
- Store followed by load to the same address: the load returns the new data, because the write completes before the load is issued.
- Address wrap: none; all 256 addresses are legal, and 8'hFF is handled like any other address.
- Reset mid-operation (any state):
  - Next edge goes to IDLE with ram_we=0.
  - Pending done/rvalid is dropped; the in-flight write may or may not have occurred, per RAM sampling.
  - last_d is cleared.
- Request withdrawn before grant: legal; no side effects.

Decomposition:
- Shared include file mem_if_defs.vh holds:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - port ids (PORT_IF=1'b0, PORT_D=1'b1);
  - default AW/DW.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter holding last_d, with enable = (state==IDLE) and outputs gnt[1:0].

Test Plan:
- RAM model preloaded mem[i]=16'hA000+i, RD_LAT=1. Fetch if_addr=8'h10 -> if_gnt in cycle 0, if_rvalid in cycle 3, if_rdata=16'hA010, busy high in cycles 1-3.
- Store d_addr=8'h20, d_wdata=16'h1234 -> ram_we high exactly cycle 1 with ram_addr=8'h20, d_done in cycle 2. Then load 8'h20 -> d_rdata=16'h1234, d_done in cycle 3 of the load.
- if_req and d_req held high together for 4 accesses -> grants in order D, IF, D, IF, with no grant while busy.
- RD_LAT=2, load d_addr=8'hFF -> d_done in cycle 4, d_rdata=16'hA0FF, if_rdata unchanged.
- Assert reset during WAIT of a fetch -> next cycle state=IDLE, if_rvalid never pulses, no gnt while reset is high. After release, a data request is granted first on contention.
- Store 16'hBEEF then withdraw d_req -> d_rdata keeps its previous value (16'h1234), and ram_addr/ram_din hold 8'h20/16'hBEEF in IDLE.
